// File: rtl/vme_reg_bank.sv
// vme_reg_bank: VME-mapped bank of NUM_REGS user registers.
// Writes go through an optional input pipeline stage, update the register,
// pulse a per-register strobe and then wait (bounded by TIMEOUT) for the
// user to acknowledge. Reads bypass the write FSM entirely and are returned
// through an optional output pipeline stage.
module vme_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 16,
  parameter int NUM_REGS   = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int WR_PIPE    = 1,
  parameter int RD_PIPE    = 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [ADDR_WIDTH-1:0]        VMEAddr,
  input  logic [DATA_WIDTH-1:0]        VMEWrData,
  input  logic                         VMERdMem,
  input  logic                         VMEWrMem,
  output logic [DATA_WIDTH-1:0]        VMERdData,
  output logic                         VMERdDone,
  output logic                         VMEWrDone,
  output logic                         VMERdError,
  output logic                         VMEWrError,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]          wr_strobe_o,
  input  logic [NUM_REGS-1:0]          wr_ack_i
);

  typedef enum logic {S_IDLE, S_WAIT_ACK} state_t;

  // One-hot decode of a word address; all-zero means out of range.
  function automatic logic [NUM_REGS-1:0] addr_dec(input logic [ADDR_WIDTH-1:0] a);
    addr_dec = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (a == ADDR_WIDTH'(i)) addr_dec[i] = 1'b1;
  endfunction

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
  assign regs_o = r_regs;

  // Only the low REG_WIDTH bits of write data are stored.
  logic w_unused_wdata;
  assign w_unused_wdata = ^VMEWrData;

  // ---------------- write input pipeline ----------------
  logic                  w_wr_req;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [REG_WIDTH-1:0]  w_wr_data;

  generate
    if (WR_PIPE != 0) begin : g_wp
      logic                  r_wp_req;
      logic [ADDR_WIDTH-1:0] r_wp_addr;
      logic [REG_WIDTH-1:0]  r_wp_data;
      // Delay the write request, address and data by one cycle.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          r_wp_req  <= 1'b0;
          r_wp_addr <= '0;
          r_wp_data <= '0;
        end else begin
          r_wp_req  <= VMEWrMem;
          r_wp_addr <= VMEAddr;
          r_wp_data <= VMEWrData[REG_WIDTH-1:0];
        end
      end
      assign w_wr_req  = r_wp_req;
      assign w_wr_addr = r_wp_addr;
      assign w_wr_data = r_wp_data;
    end else begin : g_wp0
      assign w_wr_req  = VMEWrMem;
      assign w_wr_addr = VMEAddr;
      assign w_wr_data = VMEWrData[REG_WIDTH-1:0];
    end
  endgenerate

  // ---------------- write FSM ----------------
  logic [NUM_REGS-1:0] w_wr_dec;
  assign w_wr_dec = addr_dec(w_wr_addr);

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_cnt, w_cnt_nxt;
  logic [NUM_REGS-1:0] r_wr_sel, w_sel_nxt;   // one-hot of the register awaiting ack
  logic                w_commit;
  logic                w_done_nxt, w_err_nxt;
  logic [NUM_REGS-1:0] w_strobe_nxt;

  // Next-state and registered-output decode; an ack beats a coincident timeout.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = r_wr_sel;
    w_commit     = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_strobe_nxt = '0;
    case (r_state)
      S_IDLE: begin
        if (w_wr_req) begin
          if (|w_wr_dec) begin
            w_commit     = 1'b1;
            w_strobe_nxt = w_wr_dec;
            w_sel_nxt    = w_wr_dec;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_WAIT_ACK;
          end else begin
            w_done_nxt = 1'b1;
            w_err_nxt  = 1'b1;
          end
        end
      end
      S_WAIT_ACK: begin
        // New write requests are dropped here.
        if (|(wr_ack_i & r_wr_sel)) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_cnt == 8'(TIMEOUT - 1)) begin
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, wait counter and write handshake outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wr_sel    <= '0;
      VMEWrDone   <= 1'b0;
      VMEWrError  <= 1'b0;
      wr_strobe_o <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wr_sel    <= w_sel_nxt;
      VMEWrDone   <= w_done_nxt;
      VMEWrError  <= w_err_nxt;
      wr_strobe_o <= w_strobe_nxt;
    end
  end

  // Register storage; updated only when the FSM accepts a write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (w_commit && w_wr_dec[i]) r_regs[i] <= w_wr_data;
    end
  end

  // ---------------- read path ----------------
  // Registers are sampled on the edge that captures the read strobe, so a
  // write committing on that same edge is not yet visible.
  logic [NUM_REGS-1:0]   w_rd_dec;
  logic [DATA_WIDTH-1:0] w_rd_val;
  assign w_rd_dec = addr_dec(VMEAddr);

  // Zero-extended mux of the addressed register; 0 when out of range.
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_rd_dec[i]) w_rd_val = DATA_WIDTH'(r_regs[i]);
  end

  logic                  w_rd_vld, w_rd_err;
  logic [DATA_WIDTH-1:0] w_rd_data;

  generate
    if (RD_PIPE != 0) begin : g_rp
      logic                  r_rp_vld, r_rp_err;
      logic [DATA_WIDTH-1:0] r_rp_data;
      // Extra stage holding the snapshot taken at the read strobe.
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
          r_rp_vld  <= 1'b0;
          r_rp_err  <= 1'b0;
          r_rp_data <= '0;
        end else begin
          r_rp_vld <= VMERdMem;
          r_rp_err <= VMERdMem & ~(|w_rd_dec);
          if (VMERdMem) r_rp_data <= w_rd_val;
        end
      end
      assign w_rd_vld  = r_rp_vld;
      assign w_rd_err  = r_rp_err;
      assign w_rd_data = r_rp_data;
    end else begin : g_rp0
      assign w_rd_vld  = VMERdMem;
      assign w_rd_err  = ~(|w_rd_dec);
      assign w_rd_data = w_rd_val;
    end
  endgenerate

  // Read response; data is held between reads.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      VMERdData  <= '0;
      VMERdDone  <= 1'b0;
      VMERdError <= 1'b0;
    end else begin
      VMERdDone  <= w_rd_vld;
      VMERdError <= w_rd_vld & w_rd_err;
      if (w_rd_vld) VMERdData <= w_rd_data;
    end
  end

endmodule

// File: doc/vme_reg_bank.md
VME_REG_BANK -- requirements
Module: vme_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: VME data bus width.
REQ-002 SHALL have parameter REG_WIDTH, default 16: register width, 1..DATA_WIDTH.
REQ-003 SHALL have parameter NUM_REGS, default 4: register count, 1..2**ADDR_WIDTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 2: word address width.
REQ-005 SHALL have parameter WR_PIPE, default 1: write-input pipeline stages, 0 or 1.
REQ-006 SHALL have parameter RD_PIPE, default 1: read-output pipeline stages, 0 or 1.
REQ-007 SHALL have parameter TIMEOUT, default 15: max wait cycles for user write ack, 1..255.
REQ-008 SHALL have one clock and an asynchronous active-high reset: Clk  in  1  clock; Rst  in  1  reset.
REQ-009 SHALL have ports: VMEAddr  in  ADDR_WIDTH  word address; VMEWrData  in  DATA_WIDTH  write data; VMERdMem  in  1  read strobe; VMEWrMem  in  1  write strobe.
REQ-010 SHALL have ports: VMERdData  out  DATA_WIDTH  read data; VMERdDone  out  1  read ack; VMEWrDone  out  1  write ack; VMERdError  out  1  read error; VMEWrError  out  1  write error.
REQ-011 SHALL have ports: regs_o  out  NUM_REGS*REG_WIDTH  register values, reg i at [i*REG_WIDTH +: REG_WIDTH]; wr_strobe_o  out  NUM_REGS  update pulse; wr_ack_i  in  NUM_REGS  user ack.

Function
REQ-012 VMERdMem, VMEWrMem are one-cycle pulses; address and write data are sampled with the strobe and delayed WR_PIPE cycles.
REQ-013 Write FSM states: IDLE, WAIT_ACK.
REQ-014 IDLE + delayed write request, address < NUM_REGS: reg[addr] <= VMEWrData[REG_WIDTH-1:0] on the next edge; wr_strobe_o[addr] pulses that same cycle; FSM -> WAIT_ACK; wait counter cleared.
REQ-015 IDLE + delayed write request, address >= NUM_REGS: no register change, no strobe; VMEWrDone and VMEWrError pulse one cycle on the next edge; FSM stays IDLE.
REQ-016 WAIT_ACK, wr_ack_i[latched addr] = 1: VMEWrDone pulses one cycle on the next edge; FSM -> IDLE.
REQ-017 WAIT_ACK, no ack, counter = TIMEOUT-1: VMEWrDone and VMEWrError pulse one cycle; FSM -> IDLE; the register keeps the new value.
REQ-018 wr_ack_i present in the same cycle as the timeout: ack wins; no error.
REQ-019 A write request while in WAIT_ACK is dropped: no update, no Done.
REQ-020 wr_ack_i bits in IDLE, or for a non-latched index, are ignored.
REQ-021 Minimum write latency, strobe to VMEWrDone = WR_PIPE + 2 cycles, with ack returned in the strobe cycle.
REQ-022 Reads are independent of write FSM state.
REQ-023 Read of address < NUM_REGS returns the register zero-extended to DATA_WIDTH.
REQ-024 Read of address >= NUM_REGS returns 0 and asserts VMERdError together with VMERdDone.
REQ-025 VMERdDone pulses one cycle, RD_PIPE+1 cycles after VMERdMem; VMERdData is valid in that cycle and holds its value until the next read.
REQ-026 A read and a register update on the same edge: the read returns the pre-write value.
REQ-027 regs_o reflects the register contents directly, with no extra delay.

Reset
REQ-028 Rst asserted (async): all registers, VMERdData and pipeline stages = 0; all Done/Error/strobe outputs = 0; FSM = IDLE; counter = 0.
REQ-029 Rst during WAIT_ACK aborts the transaction: no Done is issued after release.
REQ-030 Reset release is synchronous to Clk; the first request is accepted on the first edge after release.

Verification
REQ-031 Defaults, write 0xDEADBEEF to addr 2, wr_ack_i[2] returned 1 cycle after strobe -> regs_o[47:32] = 0xBEEF; wr_strobe_o = 4'b0100 for 1 cycle; VMEWrDone without error.
REQ-032 Write addr 1, no ack -> VMEWrDone and VMEWrError together, 15 cycles after the strobe; reg1 updated.
REQ-033 NUM_REGS = 3, write and read addr 3 -> no strobe; WrDone + WrError; RdData = 0 with RdDone + RdError.
REQ-034 Read addr 0 on the same edge a write of 0x1234 to addr 0 commits (old value 0x00AA) -> RdData = 0x000000AA; next read = 0x00001234.
REQ-035 Second write during WAIT_ACK -> dropped; exactly one Done; register holds the first value.
REQ-036 WR_PIPE = 0, RD_PIPE = 0 -> read Done 1 cycle after strobe; write Done 2 cycles after strobe with immediate ack; Rst mid-WAIT_ACK -> all outputs 0, no Done.
